disk_track_loader: RTL



---
 rtl/disk_loader_pkg.sv | 19 +
 rtl/drive_track_tracker.sv | 37 +++
 rtl/disk_track_loader.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/disk_loader_pkg.sv
// Shared types and helpers for the multi-drive disk track loader.
package disk_loader_pkg;

  // Transfer FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2
  } load_state_t;

  // Size of one hps_io virtual-disk sector.
  localparam int unsigned SECTOR_BYTES = 512;

  // First LBA of a track image: tracks are stored back to back, spt sectors each.
  function automatic logic [31:0] track_lba(input logic [31:0] trk, input logic [31:0] spt);
    return trk * spt;
  endfunction

endpackage

// File: rtl/drive_track_tracker.sv
// Per-drive bookkeeping: the track currently held in the buffer and whether a
// freshly mounted image still has to be loaded.
module drive_track_tracker
  import disk_loader_pkg::*;
#(
  parameter int TRACK_W = 6
) (
  input  logic               clk_sys,
  input  logic               reset,
  input  logic [TRACK_W-1:0] track,
  input  logic               img_mounted,
  input  logic               service,      // arbiter picked this drive in IDLE
  output logic [TRACK_W-1:0] cur_track,
  output logic               pending,
  output logic               need_service
);

  logic pending_q;

  // cur_track resets to all-ones so the first requested track always loads.
  // A mount seen in the same cycle the drive is picked is already folded into
  // that service via the combinational pending, so the clear wins there.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      cur_track <= '1;
      pending_q <= 1'b0;
    end else begin
      if (service) cur_track <= track;
      if (service)          pending_q <= 1'b0;
      else if (img_mounted) pending_q <= 1'b1;
    end
  end

  assign pending      = pending_q | img_mounted;
  assign need_service = (track != cur_track) | pending;

endmodule

// File: rtl/disk_track_loader.sv
// Multi-drive track loader between hps_io sector requests and the controller's
// track RAM, with optional write-back of dirty tracks.
//
// Request/ack semantics: sd_rd[d]/sd_wr[d] is a level held from transfer start
// until the ack rise of the last sector. Each rising edge of sd_ack[d] means
// hps_io accepted the sector at sd_lba (we then advance sd_lba); each falling
// edge means that sector's bytes are done (we then advance track_sec). The
// transfer ends on the ack fall that finds the request already low.
module disk_track_loader
  import disk_loader_pkg::*;
#(
  parameter int NUM_DRIVES        = 2,
  parameter int SECTORS_PER_TRACK = 13,
  parameter int TRACK_W           = 6,
  parameter int WRITE_BACK        = 1,
  parameter int WAIT_ALL          = 0
) (
  input  logic                                          clk_sys,
  input  logic                                          reset,
  input  logic [NUM_DRIVES*TRACK_W-1:0]                 track,
  input  logic [NUM_DRIVES-1:0]                         img_mounted,
  input  logic [NUM_DRIVES-1:0]                         img_present,
  input  logic [NUM_DRIVES-1:0]                         track_dirty,
  output logic [NUM_DRIVES-1:0]                         dirty_clr,
  output logic [31:0]                                   sd_lba,
  output logic [NUM_DRIVES-1:0]                         sd_rd,
  output logic [NUM_DRIVES-1:0]                         sd_wr,
  input  logic [NUM_DRIVES-1:0]                         sd_ack,
  output logic [((NUM_DRIVES > 1) ? $clog2(NUM_DRIVES) : 1)-1:0] active_drive,
  output logic [((SECTORS_PER_TRACK > 1) ? $clog2(SECTORS_PER_TRACK) : 1)-1:0] track_sec,
  output logic                                          cpu_wait,
  output logic                                          busy,
  output load_state_t                                   state_dbg
);

  localparam int DRV_W = (NUM_DRIVES > 1) ? $clog2(NUM_DRIVES) : 1;
  localparam int SEC_W = (SECTORS_PER_TRACK > 1) ? $clog2(SECTORS_PER_TRACK) : 1;
  localparam logic [31:0] SPT32 = 32'(SECTORS_PER_TRACK);

  load_state_t             state;
  logic [DRV_W-1:0]        drv;
  logic [NUM_DRIVES-1:0]   ack_prev;
  logic [TRACK_W-1:0]      trk     [NUM_DRIVES];
  logic [TRACK_W-1:0]      cur_trk [NUM_DRIVES];
  logic [NUM_DRIVES-1:0]   need, pend, take;
  logic [NUM_DRIVES-1:0]   sel_onehot, drv_onehot;
  logic [DRV_W-1:0]        sel_drv;
  logic                    sel_valid;
  logic                    ack_rise, ack_fall, req_on;
  logic [NUM_DRIVES-1:0]   mount_clr;

  for (genvar g = 0; g < NUM_DRIVES; g++) begin : g_drv
    assign trk[g] = track[g*TRACK_W +: TRACK_W];

    drive_track_tracker #(.TRACK_W(TRACK_W)) u_tracker (
      .clk_sys      (clk_sys),
      .reset        (reset),
      .track        (trk[g]),
      .img_mounted  (img_mounted[g]),
      .service      (take[g]),
      .cur_track    (cur_trk[g]),
      .pending      (pend[g]),
      .need_service (need[g])
    );
  end

  // Fixed-priority arbiter: lowest-numbered drive needing service wins.
  always_comb begin
    sel_valid = 1'b0;
    sel_drv   = '0;
    for (int d = NUM_DRIVES - 1; d >= 0; d--) begin
      if (need[d]) begin
        sel_valid = 1'b1;
        sel_drv   = DRV_W'(d);
      end
    end
    for (int d = 0; d < NUM_DRIVES; d++) begin
      sel_onehot[d] = (sel_drv == DRV_W'(d));
      drv_onehot[d] = (drv == DRV_W'(d));
    end
    take = (state == ST_IDLE && sel_valid) ? sel_onehot : '0;
  end

  // Only the active drive's ack edges matter; others and IDLE are ignored.
  assign ack_rise  = sd_ack[drv] & ~ack_prev[drv];
  assign ack_fall  = ~sd_ack[drv] & ack_prev[drv];
  assign req_on    = |(sd_rd | sd_wr);
  assign mount_clr = (WRITE_BACK != 0) ? img_mounted : '0;

  // Transfer FSM: flush (optional) then load the selected drive's track.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state     <= ST_IDLE;
      drv       <= '0;
      ack_prev  <= '0;
      sd_lba    <= '0;
      track_sec <= '0;
      sd_rd     <= '0;
      sd_wr     <= '0;
      cpu_wait  <= 1'b0;
      dirty_clr <= '0;
    end else begin
      ack_prev  <= sd_ack;
      dirty_clr <= mount_clr;
      unique case (state)
        ST_IDLE: begin
          if (sel_valid && img_present[sel_drv]) begin
            drv       <= sel_drv;
            track_sec <= '0;
            cpu_wait  <= 1'b1;
            if (WRITE_BACK != 0 && track_dirty[sel_drv] && !pend[sel_drv]) begin
              state  <= ST_WRITE;
              sd_lba <= track_lba(32'(cur_trk[sel_drv]), SPT32);
              sd_wr  <= sel_onehot;
            end else begin
              state  <= ST_READ;
              sd_lba <= track_lba(32'(trk[sel_drv]), SPT32);
              sd_rd  <= sel_onehot;
            end
          end
        end
        ST_WRITE, ST_READ: begin
          if (ack_rise) begin
            sd_lba <= sd_lba + 32'd1;
            if (track_sec == SEC_W'(SECTORS_PER_TRACK - 1)) begin
              sd_rd <= '0;
              sd_wr <= '0;
            end
          end
          if (ack_fall) begin
            track_sec <= track_sec + 1'b1;
            if (state == ST_READ && WAIT_ALL == 0) cpu_wait <= 1'b0;
            if (!req_on) begin
              if (state == ST_WRITE) begin
                // cur_track already holds the new track, so reload from it.
                state     <= ST_READ;
                dirty_clr <= mount_clr | drv_onehot;
                sd_lba    <= track_lba(32'(cur_trk[drv]), SPT32);
                track_sec <= '0;
                sd_rd     <= drv_onehot;
              end else begin
                state    <= ST_IDLE;
                cpu_wait <= 1'b0;
              end
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy         = (state != ST_IDLE);
  assign active_drive = drv;
  assign state_dbg    = state;

endmodule
